// File: rtl/ctrl_fsm_trap_pkg.sv
// Shared encodings for the multi-cycle control FSM with trap support:
// state, instruction class, function, and datapath select codes.
package ctrl_fsm_trap_pkg;

    localparam int INST_TYPE_WIDTH = 4;
    localparam int ALU_COMP_WIDTH  = 3;
    localparam int FUNCT_WIDTH     = 4;

    localparam int ALU_COMP_EQ  = 0;
    localparam int ALU_COMP_LT  = 1;
    localparam int ALU_COMP_LTU = 2;

    typedef enum logic [2:0] {
        STATE_RESET, STATE_FETCH, STATE_DECODE, STATE_EXEC, STATE_MEM, STATE_TRAP
    } state_t;

    typedef enum logic [INST_TYPE_WIDTH-1:0] {
        INST_TYPE_IMM, INST_TYPE_INT_IMM, INST_TYPE_INT_REG, INST_TYPE_BRANCH,
        INST_TYPE_JAL, INST_TYPE_JALR, INST_TYPE_AUIPC, INST_TYPE_LOAD,
        INST_TYPE_STORE, INST_TYPE_FENCE
    } inst_type_t;

    // Integer ops and branch conditions share one decoded function field.
    typedef enum logic [FUNCT_WIDTH-1:0] {
        FUNCT_ADD, FUNCT_SUB, FUNCT_SLL, FUNCT_SLT, FUNCT_SLTU, FUNCT_XOR,
        FUNCT_SRL, FUNCT_SRA, FUNCT_OR, FUNCT_AND, FUNCT_EQ, FUNCT_NEQ,
        FUNCT_LT, FUNCT_GTE, FUNCT_LTU, FUNCT_GTEU
    } funct_t;

    typedef enum logic [3:0] {
        ALU_OP_NOP, ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU,
        ALU_OP_XOR, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_OR, ALU_OP_AND
    } alu_op_t;

    typedef enum logic [1:0] {
        RD_DIN_SEL_IMM, RD_DIN_SEL_ALU, RD_DIN_SEL_MEM
    } rd_din_sel_t;

    typedef enum logic [2:0] {
        PC_NEXT_SEL_STALL, PC_NEXT_SEL_INCR, PC_NEXT_SEL_ADD_IMM,
        PC_NEXT_SEL_ADD_RS1_IMM, PC_NEXT_SEL_TRAP
    } pc_next_sel_t;

    typedef enum logic {
        ALU_DIN1_SEL_RS1, ALU_DIN1_SEL_PC
    } alu_din1_sel_t;

    typedef enum logic [1:0] {
        ALU_DIN2_SEL_IMM, ALU_DIN2_SEL_RS2, ALU_DIN2_SEL_CONST_4
    } alu_din2_sel_t;

    typedef enum logic [1:0] {
        TRAP_CAUSE_ILLEGAL, TRAP_CAUSE_FETCH_TIMEOUT, TRAP_CAUSE_MEM_TIMEOUT
    } trap_cause_t;

endpackage

// File: rtl/ctrl_fsm_trap_if.sv
// Control bundle between decoder/ALU/bus responses and the datapath muxes.
interface ctrl_fsm_trap_if
    import ctrl_fsm_trap_pkg::*;
#(
    parameter int INSTRET_WIDTH = 32
);
    inst_type_t                 inst_type;
    logic                       inst_valid;
    logic                       inst_illegal;
    logic [ALU_COMP_WIDTH-1:0]  alu_comp;
    funct_t                     funct;
    logic                       data_valid;
    logic                       inst_fetch;
    logic                       load_data;
    logic                       store_data;
    logic                       rd_en;
    logic                       rs1_en;
    logic                       rs2_en;
    rd_din_sel_t                rd_din_sel;
    pc_next_sel_t               pc_next_sel;
    alu_din1_sel_t              alu_din1_sel;
    alu_din2_sel_t              alu_din2_sel;
    alu_op_t                    alu_op;
    logic                       trap;
    trap_cause_t                trap_cause;
    logic [INSTRET_WIDTH-1:0]   instret;

    modport master (
        input  inst_type, inst_valid, inst_illegal, alu_comp, funct, data_valid,
        output inst_fetch, load_data, store_data, rd_en, rs1_en, rs2_en,
               rd_din_sel, pc_next_sel, alu_din1_sel, alu_din2_sel, alu_op,
               trap, trap_cause, instret
    );

    modport slave (
        output inst_type, inst_valid, inst_illegal, alu_comp, funct, data_valid,
        input  inst_fetch, load_data, store_data, rd_en, rs1_en, rs2_en,
               rd_din_sel, pc_next_sel, alu_din1_sel, alu_din2_sel, alu_op,
               trap, trap_cause, instret
    );
endinterface

// File: rtl/ctrl_wait_timer.sv
// Bus wait counter: cleared on every state change, saturating, and flags
// the cycle on which the selected limit would be reached.
module ctrl_wait_timer #(
    parameter int FETCH_TIMEOUT = 16,
    parameter int MEM_TIMEOUT   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    input  logic sel_mem,
    output logic timeout
);
    localparam int MAX_LIMIT = (FETCH_TIMEOUT > MEM_TIMEOUT) ? FETCH_TIMEOUT : MEM_TIMEOUT;
    localparam int CNT_WIDTH = (MAX_LIMIT > 0) ? $clog2(MAX_LIMIT + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] count_reg;
    logic [31:0]          limit;

    assign limit = sel_mem ? 32'(MEM_TIMEOUT) : 32'(FETCH_TIMEOUT);

    // Fires on the last permitted wait cycle so the FSM leaves exactly at the limit.
    assign timeout = inc && (limit != 32'd0) && ((32'(count_reg) + 32'd1) == limit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + CNT_WIDTH'(1);
        end
    end
endmodule

// File: rtl/ctrl_fsm_trap.sv
// Multi-cycle core control FSM (FETCH/DECODE/EXEC/MEM) with bus-timeout and
// illegal-instruction traps and a retired-instruction counter.
module ctrl_fsm_trap
    import ctrl_fsm_trap_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 16,
    parameter int MEM_TIMEOUT   = 16,
    parameter int INSTRET_WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    ctrl_fsm_trap_if.master bus
);
    state_t                   state_reg, state_next;
    logic                     state_change_reg;
    logic [INSTRET_WIDTH-1:0] instret_reg;
    trap_cause_t              trap_cause_reg, trap_cause_next;
    logic                     retire;
    logic                     wait_inc;
    logic                     timeout;
    logic                     branch_taken;

    function automatic alu_op_t get_int_alu_op(input funct_t f);
        case (f)
            FUNCT_ADD:  return ALU_OP_ADD;
            FUNCT_SUB:  return ALU_OP_SUB;
            FUNCT_SLL:  return ALU_OP_SLL;
            FUNCT_SLT:  return ALU_OP_SLT;
            FUNCT_SLTU: return ALU_OP_SLTU;
            FUNCT_XOR:  return ALU_OP_XOR;
            FUNCT_SRL:  return ALU_OP_SRL;
            FUNCT_SRA:  return ALU_OP_SRA;
            FUNCT_OR:   return ALU_OP_OR;
            FUNCT_AND:  return ALU_OP_AND;
            default:    return ALU_OP_NOP;
        endcase
    endfunction

    // Kept outside the main comb block so timeout never feeds back into itself.
    assign wait_inc = ((state_reg == STATE_FETCH) && !bus.inst_valid) ||
                      ((state_reg == STATE_MEM)   && !bus.data_valid);

    ctrl_wait_timer #(
        .FETCH_TIMEOUT (FETCH_TIMEOUT),
        .MEM_TIMEOUT   (MEM_TIMEOUT)
    ) wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_next != state_reg),
        .inc     (wait_inc),
        .sel_mem (state_reg == STATE_MEM),
        .timeout (timeout)
    );

    always_comb begin
        case (bus.funct)
            FUNCT_EQ:   branch_taken =  bus.alu_comp[ALU_COMP_EQ];
            FUNCT_NEQ:  branch_taken = !bus.alu_comp[ALU_COMP_EQ];
            FUNCT_LT:   branch_taken =  bus.alu_comp[ALU_COMP_LT];
            FUNCT_GTE:  branch_taken = !bus.alu_comp[ALU_COMP_LT];
            FUNCT_LTU:  branch_taken =  bus.alu_comp[ALU_COMP_LTU];
            FUNCT_GTEU: branch_taken = !bus.alu_comp[ALU_COMP_LTU];
            default:    branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_next       = state_reg;
        trap_cause_next  = trap_cause_reg;
        retire           = 1'b0;
        bus.inst_fetch   = 1'b0;
        bus.load_data    = 1'b0;
        bus.store_data   = 1'b0;
        bus.rd_en        = 1'b0;
        bus.rs1_en       = 1'b0;
        bus.rs2_en       = 1'b0;
        bus.rd_din_sel   = RD_DIN_SEL_IMM;
        bus.pc_next_sel  = PC_NEXT_SEL_STALL;
        bus.alu_din1_sel = ALU_DIN1_SEL_RS1;
        bus.alu_din2_sel = ALU_DIN2_SEL_IMM;
        bus.alu_op       = ALU_OP_NOP;
        bus.trap         = 1'b0;
        case (state_reg)
            STATE_RESET: state_next = STATE_FETCH;
            STATE_FETCH: begin
                bus.inst_fetch = state_change_reg;
                if (bus.inst_valid) begin
                    state_next = (bus.inst_type == INST_TYPE_JAL) ? STATE_EXEC : STATE_DECODE;
                end else if (timeout) begin
                    state_next      = STATE_TRAP;
                    trap_cause_next = TRAP_CAUSE_FETCH_TIMEOUT;
                end
            end
            STATE_DECODE: begin
                if (bus.inst_illegal) begin
                    state_next      = STATE_TRAP;
                    trap_cause_next = TRAP_CAUSE_ILLEGAL;
                end else begin
                    case (bus.inst_type)
                        INST_TYPE_IMM: begin
                            bus.rd_en       = 1'b1;
                            bus.rd_din_sel  = RD_DIN_SEL_IMM;
                            bus.pc_next_sel = PC_NEXT_SEL_INCR;
                            state_next      = STATE_FETCH;
                            retire          = 1'b1;
                        end
                        INST_TYPE_FENCE: begin
                            bus.pc_next_sel = PC_NEXT_SEL_INCR;
                            state_next      = STATE_FETCH;
                            retire          = 1'b1;
                        end
                        INST_TYPE_INT_REG, INST_TYPE_BRANCH, INST_TYPE_STORE: begin
                            bus.rs1_en = 1'b1;
                            bus.rs2_en = 1'b1;
                            state_next = STATE_EXEC;
                        end
                        INST_TYPE_INT_IMM, INST_TYPE_LOAD, INST_TYPE_JALR: begin
                            bus.rs1_en = 1'b1;
                            state_next = STATE_EXEC;
                        end
                        default: state_next = STATE_EXEC;
                    endcase
                end
            end
            STATE_EXEC: begin
                state_next = STATE_FETCH;
                retire     = 1'b1;
                case (bus.inst_type)
                    INST_TYPE_INT_IMM, INST_TYPE_INT_REG: begin
                        bus.alu_op       = get_int_alu_op(bus.funct);
                        bus.alu_din2_sel = (bus.inst_type == INST_TYPE_INT_REG) ?
                                           ALU_DIN2_SEL_RS2 : ALU_DIN2_SEL_IMM;
                        bus.rd_en        = 1'b1;
                        bus.rd_din_sel   = RD_DIN_SEL_ALU;
                        bus.pc_next_sel  = PC_NEXT_SEL_INCR;
                    end
                    INST_TYPE_BRANCH: begin
                        bus.alu_din2_sel = ALU_DIN2_SEL_RS2;
                        bus.pc_next_sel  = branch_taken ? PC_NEXT_SEL_ADD_IMM : PC_NEXT_SEL_INCR;
                    end
                    INST_TYPE_JAL, INST_TYPE_JALR: begin
                        bus.alu_op       = ALU_OP_ADD;
                        bus.alu_din1_sel = ALU_DIN1_SEL_PC;
                        bus.alu_din2_sel = ALU_DIN2_SEL_CONST_4;
                        bus.rd_en        = 1'b1;
                        bus.rd_din_sel   = RD_DIN_SEL_ALU;
                        bus.pc_next_sel  = (bus.inst_type == INST_TYPE_JAL) ?
                                           PC_NEXT_SEL_ADD_IMM : PC_NEXT_SEL_ADD_RS1_IMM;
                    end
                    INST_TYPE_AUIPC: begin
                        bus.alu_op       = ALU_OP_ADD;
                        bus.alu_din1_sel = ALU_DIN1_SEL_PC;
                        bus.rd_en        = 1'b1;
                        bus.rd_din_sel   = RD_DIN_SEL_ALU;
                        bus.pc_next_sel  = PC_NEXT_SEL_INCR;
                    end
                    INST_TYPE_LOAD, INST_TYPE_STORE: begin
                        bus.alu_op     = ALU_OP_ADD;
                        bus.load_data  = (bus.inst_type == INST_TYPE_LOAD)  && state_change_reg;
                        bus.store_data = (bus.inst_type == INST_TYPE_STORE) && state_change_reg;
                        state_next     = STATE_MEM;
                        retire         = 1'b0;
                    end
                    default: ;
                endcase
            end
            STATE_MEM: begin
                bus.alu_op = ALU_OP_ADD;
                if (bus.data_valid) begin
                    if (bus.inst_type == INST_TYPE_LOAD) begin
                        bus.rd_en      = 1'b1;
                        bus.rd_din_sel = RD_DIN_SEL_MEM;
                    end
                    bus.pc_next_sel = PC_NEXT_SEL_INCR;
                    state_next      = STATE_FETCH;
                    retire          = 1'b1;
                end else if (timeout) begin
                    state_next      = STATE_TRAP;
                    trap_cause_next = TRAP_CAUSE_MEM_TIMEOUT;
                end
            end
            STATE_TRAP: begin
                bus.trap        = 1'b1;
                bus.pc_next_sel = PC_NEXT_SEL_TRAP;
                state_next      = STATE_FETCH;
            end
            default: state_next = STATE_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= STATE_RESET;
            state_change_reg <= 1'b0;
            instret_reg      <= '0;
            trap_cause_reg   <= TRAP_CAUSE_ILLEGAL;
        end else begin
            state_reg        <= state_next;
            state_change_reg <= (state_next != state_reg);
            trap_cause_reg   <= trap_cause_next;
            if (retire) begin
                instret_reg <= instret_reg + INSTRET_WIDTH'(1);
            end
        end
    end

    assign bus.instret    = instret_reg;
    assign bus.trap_cause = trap_cause_reg;
endmodule

// File: tb/tb_ctrl_fsm_trap.sv
// Directed bench for ctrl_fsm_trap: instruction flows, timeouts, traps, resets.
module tb_ctrl_fsm_trap;
    import ctrl_fsm_trap_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    ctrl_fsm_trap_if #(.INSTRET_WIDTH(32)) bus ();

    ctrl_fsm_trap #(
        .FETCH_TIMEOUT (8),
        .MEM_TIMEOUT   (4),
        .INSTRET_WIDTH (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in FETCH, advance one edge, drop inst_valid.
    task automatic issue(input inst_type_t t, input funct_t f);
        bus.inst_valid = 1'b1;
        bus.inst_type  = t;
        bus.funct      = f;
        tick();
        bus.inst_valid = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b0;
        bus.inst_type    = INST_TYPE_IMM;
        bus.inst_valid   = 1'b0;
        bus.inst_illegal = 1'b0;
        bus.alu_comp     = 3'b000;
        bus.funct        = FUNCT_ADD;
        bus.data_valid   = 1'b0;
        repeat (2) tick();
        check_eq("rst_inst_fetch", bus.inst_fetch, 0);
        check_eq("rst_rd_en", bus.rd_en, 0);
        check_eq("rst_pc_sel", bus.pc_next_sel, PC_NEXT_SEL_STALL);
        check_eq("rst_alu_op", bus.alu_op, ALU_OP_NOP);
        check_eq("rst_trap", bus.trap, 0);
        check_eq("rst_instret", bus.instret, 0);
        check_eq("rst_trap_cause", bus.trap_cause, 0);
        $display("txn reset: defaults observed");

        rst = 1'b1;
        tick();
        check_eq("first_fetch_pulse", bus.inst_fetch, 1);

        // ADDI
        issue(INST_TYPE_INT_IMM, FUNCT_ADD);
        check_eq("addi_dec_rs1", bus.rs1_en, 1);
        check_eq("addi_dec_rs2", bus.rs2_en, 0);
        check_eq("addi_dec_rd", bus.rd_en, 0);
        tick();
        check_eq("addi_ex_rd", bus.rd_en, 1);
        check_eq("addi_ex_alu", bus.alu_op, ALU_OP_ADD);
        check_eq("addi_ex_pc", bus.pc_next_sel, PC_NEXT_SEL_INCR);
        check_eq("addi_ex_rdsel", bus.rd_din_sel, RD_DIN_SEL_ALU);
        check_eq("addi_ex_instret", bus.instret, 0);
        tick();
        check_eq("addi_instret", bus.instret, 1);
        check_eq("addi_next_fetch", bus.inst_fetch, 1);
        tick();
        check_eq("fetch_single_pulse", bus.inst_fetch, 0);
        $display("txn ADDI: instret=%0d", bus.instret);

        // BEQ taken, BNE not taken
        bus.alu_comp = 3'b001;
        issue(INST_TYPE_BRANCH, FUNCT_EQ);
        check_eq("beq_dec_rs1", bus.rs1_en, 1);
        check_eq("beq_dec_rs2", bus.rs2_en, 1);
        tick();
        check_eq("beq_pc", bus.pc_next_sel, PC_NEXT_SEL_ADD_IMM);
        check_eq("beq_rd", bus.rd_en, 0);
        tick();
        issue(INST_TYPE_BRANCH, FUNCT_NEQ);
        tick();
        check_eq("bne_pc", bus.pc_next_sel, PC_NEXT_SEL_INCR);
        check_eq("bne_rd", bus.rd_en, 0);
        tick();
        check_eq("branch_instret", bus.instret, 3);
        $display("txn BEQ/BNE: instret=%0d", bus.instret);

        // LOAD, data_valid on the 4th MEM cycle (coincides with the limit)
        issue(INST_TYPE_LOAD, FUNCT_ADD);
        check_eq("load_dec_rs1", bus.rs1_en, 1);
        check_eq("load_dec_rs2", bus.rs2_en, 0);
        tick();
        check_eq("load_ex_pulse", bus.load_data, 1);
        check_eq("load_ex_store", bus.store_data, 0);
        check_eq("load_ex_alu", bus.alu_op, ALU_OP_ADD);
        tick();
        check_eq("load_mem_pulse", bus.load_data, 0);
        check_eq("load_mem_rd", bus.rd_en, 0);
        check_eq("load_mem_alu", bus.alu_op, ALU_OP_ADD);
        tick();
        tick();
        check_eq("load_mem3_rd", bus.rd_en, 0);
        tick();
        bus.data_valid = 1'b1;
        #1;
        check_eq("load_dv_rd", bus.rd_en, 1);
        check_eq("load_dv_rdsel", bus.rd_din_sel, RD_DIN_SEL_MEM);
        check_eq("load_dv_pc", bus.pc_next_sel, PC_NEXT_SEL_INCR);
        check_eq("load_dv_trap", bus.trap, 0);
        tick();
        bus.data_valid = 1'b0;
        #1;
        check_eq("load_instret", bus.instret, 4);
        check_eq("load_no_trap", bus.trap, 0);
        $display("txn LOAD: instret=%0d", bus.instret);

        // STORE with no response -> mem timeout
        issue(INST_TYPE_STORE, FUNCT_ADD);
        check_eq("store_dec_rs2", bus.rs2_en, 1);
        tick();
        check_eq("store_ex_pulse", bus.store_data, 1);
        tick();
        check_eq("store_mem_pulse", bus.store_data, 0);
        repeat (3) tick();
        check_eq("store_mem4_trap", bus.trap, 0);
        tick();
        check_eq("memto_trap", bus.trap, 1);
        check_eq("memto_cause", bus.trap_cause, TRAP_CAUSE_MEM_TIMEOUT);
        check_eq("memto_pc", bus.pc_next_sel, PC_NEXT_SEL_TRAP);
        check_eq("memto_rd", bus.rd_en, 0);
        check_eq("memto_instret", bus.instret, 4);
        tick();
        check_eq("memto_trap_done", bus.trap, 0);
        check_eq("memto_refetch", bus.inst_fetch, 1);
        check_eq("memto_cause_held", bus.trap_cause, TRAP_CAUSE_MEM_TIMEOUT);
        $display("txn STORE timeout: cause=%0d", bus.trap_cause);

        // Illegal instruction
        bus.inst_illegal = 1'b1;
        issue(INST_TYPE_INT_REG, FUNCT_ADD);
        check_eq("ill_rs1", bus.rs1_en, 0);
        check_eq("ill_rs2", bus.rs2_en, 0);
        check_eq("ill_rd", bus.rd_en, 0);
        tick();
        bus.inst_illegal = 1'b0;
        #1;
        check_eq("ill_trap", bus.trap, 1);
        check_eq("ill_cause", bus.trap_cause, TRAP_CAUSE_ILLEGAL);
        tick();
        check_eq("ill_refetch", bus.inst_fetch, 1);
        check_eq("ill_instret", bus.instret, 4);
        $display("txn illegal: cause=%0d", bus.trap_cause);

        // Fetch timeout: 8 FETCH cycles without inst_valid
        repeat (7) tick();
        check_eq("fetchto_8th_trap", bus.trap, 0);
        check_eq("fetchto_8th_fetch", bus.inst_fetch, 0);
        tick();
        check_eq("fetchto_trap", bus.trap, 1);
        check_eq("fetchto_cause", bus.trap_cause, TRAP_CAUSE_FETCH_TIMEOUT);
        check_eq("fetchto_pc", bus.pc_next_sel, PC_NEXT_SEL_TRAP);
        tick();
        $display("txn fetch timeout: cause=%0d", bus.trap_cause);

        // JAL bypasses DECODE
        issue(INST_TYPE_JAL, FUNCT_ADD);
        check_eq("jal_rd", bus.rd_en, 1);
        check_eq("jal_pc", bus.pc_next_sel, PC_NEXT_SEL_ADD_IMM);
        check_eq("jal_din1", bus.alu_din1_sel, ALU_DIN1_SEL_PC);
        check_eq("jal_din2", bus.alu_din2_sel, ALU_DIN2_SEL_CONST_4);
        tick();
        check_eq("jal_instret", bus.instret, 5);
        $display("txn JAL: instret=%0d", bus.instret);

        // Reset asserted mid-MEM with a response arriving
        issue(INST_TYPE_LOAD, FUNCT_ADD);
        tick();
        tick();
        bus.data_valid = 1'b1;
        rst = 1'b0;
        #1;
        check_eq("rstmem_rd", bus.rd_en, 0);
        check_eq("rstmem_pc", bus.pc_next_sel, PC_NEXT_SEL_STALL);
        check_eq("rstmem_alu", bus.alu_op, ALU_OP_NOP);
        check_eq("rstmem_instret", bus.instret, 0);
        bus.data_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_eq("rstmem_fetch", bus.inst_fetch, 1);
        check_eq("rstmem_instret_after", bus.instret, 0);
        $display("txn reset mid-MEM: instret=%0d", bus.instret);

        // Reset asserted mid-EXEC
        issue(INST_TYPE_INT_IMM, FUNCT_ADD);
        tick();
        check_eq("rstex_rd_before", bus.rd_en, 1);
        rst = 1'b0;
        #1;
        check_eq("rstex_rd", bus.rd_en, 0);
        check_eq("rstex_alu", bus.alu_op, ALU_OP_NOP);
        tick();
        rst = 1'b1;
        tick();
        check_eq("rstex_fetch", bus.inst_fetch, 1);
        check_eq("rstex_instret", bus.instret, 0);
        $display("txn reset mid-EXEC: instret=%0d", bus.instret);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
